// File: rtl/wrr_pkg.sv
// Shared defaults and types for the weighted round-robin credit arbiter.
package wrr_pkg;

    localparam int DEF_NREQ          = 4;
    localparam int BID_W             = 4;
    localparam int DEF_CREDIT_W      = 10;
    localparam int DEF_CREDIT_INIT   = 750;
    localparam int DEF_CREDIT_MAX    = 900;
    localparam int DEF_REFILL_AMT    = 750;
    localparam int DEF_REFILL_PERIOD = 400;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/wrr_credit.sv
// One requester's credit balance: saturating debit on grant, clamped refill.
module wrr_credit
    import wrr_pkg::*;
#(
    parameter int CREDIT_W    = DEF_CREDIT_W,
    parameter int CREDIT_INIT = DEF_CREDIT_INIT,
    parameter int CREDIT_MAX  = DEF_CREDIT_MAX,
    parameter int REFILL_AMT  = DEF_REFILL_AMT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_debit,
    input  logic [BID_W-1:0]    i_bid,
    input  logic                i_refill,
    output logic [CREDIT_W-1:0] o_balance
);

    localparam logic [CREDIT_W:0] L_AMT = (CREDIT_W+1)'(REFILL_AMT);
    localparam logic [CREDIT_W:0] L_MAX = (CREDIT_W+1)'(CREDIT_MAX);

    logic [CREDIT_W-1:0] r_bal;
    logic [CREDIT_W-1:0] w_bid_ext;
    logic [CREDIT_W-1:0] w_after_debit;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_next;

    assign w_bid_ext = CREDIT_W'(i_bid);

    // Debit floors at zero; refill is applied on top of the post-debit value.
    assign w_after_debit = !i_debit                ? r_bal :
                           (r_bal >= w_bid_ext)    ? r_bal - w_bid_ext : '0;
    assign w_sum         = {1'b0, w_after_debit} + L_AMT;
    assign w_next        = !i_refill        ? w_after_debit :
                           (w_sum > L_MAX)  ? L_MAX[CREDIT_W-1:0] : w_sum[CREDIT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_bal <= CREDIT_W'(CREDIT_INIT);
        else     r_bal <= w_next;
    end

    assign o_balance = r_bal;

endmodule

// File: rtl/wrr_arbiter.sv
// Credit-weighted round-robin arbiter: one registered grant per cycle, periodic refill.
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter int NREQ          = DEF_NREQ,
    parameter int CREDIT_W      = DEF_CREDIT_W,
    parameter int CREDIT_INIT   = DEF_CREDIT_INIT,
    parameter int CREDIT_MAX    = DEF_CREDIT_MAX,
    parameter int REFILL_AMT    = DEF_REFILL_AMT,
    parameter int REFILL_PERIOD = DEF_REFILL_PERIOD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BID_W-1:0]    bid,
    input  logic                     res_ready,
    output logic [NREQ-1:0]          gnt,
    output req_idx_t                 gnt_id,
    output logic                     gnt_valid,
    output logic [NREQ*CREDIT_W-1:0] balance,
    output logic                     refill
);

    localparam int CNT_W = $clog2(REFILL_PERIOD);

    logic [CNT_W-1:0] r_refill_cnt;
    logic             w_refill_edge;
    req_idx_t         r_last;
    logic [NREQ-1:0]  w_afford;
    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_debit;
    logic             w_arb;
    req_idx_t         w_win;
    logic [NREQ-1:0]  r_gnt;
    req_idx_t         r_gnt_id;
    logic             r_gnt_valid;
    logic             r_refill;

    assign w_refill_edge = (r_refill_cnt == CNT_W'(REFILL_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_refill_cnt <= '0;
        else if (w_refill_edge) r_refill_cnt <= '0;
        else                    r_refill_cnt <= r_refill_cnt + 1'b1;
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign w_afford[i] = balance[i*CREDIT_W +: CREDIT_W] >= CREDIT_W'(bid[i*BID_W +: BID_W]);
        assign w_debit[i]  = w_arb && (w_win == req_idx_t'(i));

        wrr_credit #(
            .CREDIT_W   (CREDIT_W),
            .CREDIT_INIT(CREDIT_INIT),
            .CREDIT_MAX (CREDIT_MAX),
            .REFILL_AMT (REFILL_AMT)
        ) u_credit (
            .clk      (clk),
            .rst      (rst),
            .i_debit  (w_debit[i]),
            .i_bid    (bid[i*BID_W +: BID_W]),
            .i_refill (w_refill_edge),
            .o_balance(balance[i*CREDIT_W +: CREDIT_W])
        );
    end

    // Starvation guard: if nobody can afford their bid, any requester may win.
    assign w_elig = (|(req & w_afford)) ? (req & w_afford) : req;
    assign w_arb  = res_ready && (|req);

    always_comb begin
        logic     w_found;
        req_idx_t w_idx;
        w_win   = r_last;
        w_found = 1'b0;
        w_idx   = r_last;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = req_idx_t'((int'(r_last) + k) % NREQ);
            if (!w_found && w_elig[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_last      <= req_idx_t'(NREQ - 1);
            r_refill    <= 1'b0;
        end else begin
            r_gnt       <= w_debit;
            r_gnt_valid <= w_arb;
            r_refill    <= w_refill_edge;
            if (w_arb) begin
                r_gnt_id <= w_win;
                r_last   <= w_win;
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign refill    = r_refill;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed scoreboard bench for wrr_arbiter: expected state queued at drive time, checked after the edge.
module tb_wrr_arbiter;

    localparam int C_INIT = 750;
    localparam int C_MAX  = 900;
    localparam int C_AMT  = 750;
    localparam int C_PER  = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] bid = '0;
    logic        res_ready = 1'b0;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;
    logic [39:0] balance;
    logic        refill;

    wrr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .bid      (bid),
        .res_ready(res_ready),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .balance  (balance),
        .refill   (refill)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  gnt;
        logic        vld;
        logic [1:0]  id;
        logic [39:0] bal;
        logic        refill;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_bal[4];
    int   m_last;
    int   m_cnt;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int bidof(input logic [15:0] b, input int i);
        return int'(b[4*i +: 4]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_bal[i] = C_INIT;
        m_last = 3;
        m_cnt  = 0;
        sb.delete();
    endtask

    // Drive one cycle, queue the reference result, then check it after the edge.
    task automatic cycle(input logic [3:0] r, input logic [15:0] b, input logic rdy);
        exp_t       e;
        exp_t       got;
        logic [3:0] elig;
        int         win;
        bit         redge;
        req = r; bid = b; res_ready = rdy;
        elig = '0;
        for (int i = 0; i < 4; i++)
            if (r[i] && m_bal[i] >= bidof(b, i)) elig[i] = 1'b1;
        if (elig == 4'b0) elig = r;
        win = -1;
        if (rdy && r != 4'b0)
            for (int k = 1; k <= 4; k++)
                if (win < 0 && elig[(m_last + k) % 4]) win = (m_last + k) % 4;
        if (win >= 0) begin
            m_bal[win] = (m_bal[win] > bidof(b, win)) ? m_bal[win] - bidof(b, win) : 0;
            m_last     = win;
        end
        redge = (m_cnt == C_PER - 1);
        if (redge)
            for (int i = 0; i < 4; i++) m_bal[i] = (m_bal[i] + C_AMT > C_MAX) ? C_MAX : m_bal[i] + C_AMT;
        m_cnt = redge ? 0 : m_cnt + 1;
        e.gnt    = (win >= 0) ? 4'(1 << win) : 4'b0;
        e.vld    = (win >= 0);
        e.id     = (win >= 0) ? 2'(win) : 2'b0;
        for (int i = 0; i < 4; i++) e.bal[10*i +: 10] = 10'(m_bal[i]);
        e.refill = redge;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sb.pop_front();
        chk("gnt", 40'(gnt), 40'(got.gnt));
        chk("gnt_valid", 40'(gnt_valid), 40'(got.vld));
        if (got.vld) chk("gnt_id", 40'(gnt_id), 40'(got.id));
        chk("balance", balance, got.bal);
        chk("refill", 40'(refill), 40'(got.refill));
    endtask

    // Asserts reset between edges and checks outputs before any edge arrives.
    task automatic do_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_gnt", 40'(gnt), 40'd0);
        chk("rst_gnt_valid", 40'(gnt_valid), 40'd0);
        chk("rst_gnt_id", 40'(gnt_id), 40'd0);
        chk("rst_refill", 40'(refill), 40'd0);
        chk("rst_balance", balance, {4{10'd750}});
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_to_refill();
        while (m_cnt != C_PER - 1) cycle(4'b0, 16'h0, 1'b1);
    endtask

    initial begin
        logic [3:0] seq_a [5];
        seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        @(posedge clk); #1;

        // Equal bids rotate 0,1,2,3,0.
        do_reset();
        for (int j = 0; j < 5; j++) begin
            cycle(4'b1111, 16'h1111, 1'b1);
            chk("A_seq", 40'(gnt), 40'(seq_a[j]));
            if (j == 3) chk("A_bal_all", balance, {4{10'd749}});
        end

        // Alternation between 0 and 2 with unequal costs.
        do_reset();
        repeat (50) cycle(4'b0101, 16'h010F, 1'b1);
        chk("B_bal0", 40'(balance[9:0]), 40'd375);
        chk("B_bal2", 40'(balance[29:20]), 40'd725);

        // Requester 1 drained below its bid; starvation guard and floor at 0.
        do_reset();
        repeat (49) cycle(4'b0010, 16'h00F0, 1'b1);
        cycle(4'b0010, 16'h00A0, 1'b1);
        chk("C_bal1_low", 40'(balance[19:10]), 40'd5);
        repeat (6) begin
            cycle(4'b0011, 16'h00F1, 1'b1);
            chk("C_only0", 40'(gnt), 40'b0001);
        end
        cycle(4'b0010, 16'h00F1, 1'b1);
        chk("C_guard_gnt", 40'(gnt), 40'b0010);
        chk("C_bal1_floor", 40'(balance[19:10]), 40'd0);

        // Refill clamps at the ceiling, and a partial refill lands below it.
        do_reset();
        repeat (36) cycle(4'b0001, 16'h000F, 1'b1);
        cycle(4'b0001, 16'h000A, 1'b1);
        chk("D_bal0_200", 40'(balance[9:0]), 40'd200);
        idle_to_refill();
        cycle(4'b0, 16'h0, 1'b1);
        chk("D_bal0_900", 40'(balance[9:0]), 40'd900);
        chk("D_refill_hi", 40'(refill), 40'd1);
        cycle(4'b0, 16'h0, 1'b1);
        chk("D_refill_lo", 40'(refill), 40'd0);
        repeat (53) cycle(4'b0001, 16'h000F, 1'b1);
        cycle(4'b0001, 16'h0005, 1'b1);
        chk("D_bal0_100", 40'(balance[9:0]), 40'd100);
        idle_to_refill();
        cycle(4'b0, 16'h0, 1'b1);
        chk("D_bal0_850", 40'(balance[9:0]), 40'd850);

        // Grant coinciding with refill, then the same setup without res_ready.
        do_reset();
        repeat (40) cycle(4'b0100, 16'h0F00, 1'b1);
        cycle(4'b0100, 16'h0A00, 1'b1);
        chk("E_bal2_140a", 40'(balance[29:20]), 40'd140);
        idle_to_refill();
        cycle(4'b0100, 16'h0A00, 1'b1);
        chk("E_gnt2", 40'(gnt), 40'b0100);
        chk("E_bal2_880", 40'(balance[29:20]), 40'd880);
        repeat (49) cycle(4'b0100, 16'h0F00, 1'b1);
        cycle(4'b0100, 16'h0500, 1'b1);
        chk("E_bal2_140b", 40'(balance[29:20]), 40'd140);
        idle_to_refill();
        cycle(4'b0100, 16'h0A00, 1'b0);
        chk("E_nognt", 40'(gnt_valid), 40'd0);
        chk("E_bal2_890", 40'(balance[29:20]), 40'd890);

        // Reset mid-stream while a grant is showing.
        do_reset();
        cycle(4'b1111, 16'h1111, 1'b1);
        cycle(4'b1111, 16'h1111, 1'b1);
        chk("F_valid_before", 40'(gnt_valid), 40'd1);
        do_reset();
        cycle(4'b1111, 16'h1111, 1'b1);
        chk("F_first_after", 40'(gnt), 40'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
